// File: rtl/frame_block_writer.sv
// Packs vertically adjacent pixel groups of a raster stream into BLOCK-pixel words
// and writes them to the frame-buffer BRAM at ROWS_B*col + block_row.
module frame_block_writer #(
  parameter int unsigned WIDTH    = 320,
  parameter int unsigned HEIGHT   = 240,
  parameter int unsigned BLOCK    = 6,
  parameter int unsigned PIX_BITS = 8,
  localparam int unsigned ROWS_B  = HEIGHT / BLOCK,
  localparam int unsigned WORD    = BLOCK * PIX_BITS,
  localparam int unsigned AW      = $clog2(WIDTH * ROWS_B)
) (
  input  logic                clk_100mhz,
  input  logic                sys_rst,
  input  logic                pixel_valid,
  input  logic [PIX_BITS-1:0] pixel_data,
  input  logic                frame_start,
  output logic                wr_en,
  output logic [AW-1:0]       wr_addr,
  output logic [WORD-1:0]     wr_data,
  output logic                frame_done,
  output logic                busy
);

  localparam int unsigned CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned LW    = (BLOCK > 1) ? $clog2(BLOCK) : 1;
  localparam int unsigned BW    = (ROWS_B > 1) ? $clog2(ROWS_B) : 1;
  localparam int unsigned ACC_W = (BLOCK - 1) * PIX_BITS;

  typedef enum logic {IDLE, FILL} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       col_q, col_d;
  logic [LW-1:0]       lane_q, lane_d;
  logic [BW-1:0]       br_q, br_d;
  logic [AW-1:0]       base_q, base_d;

  logic                s1_vld_q, s1_vld_d;
  logic                s1_last_q, s1_last_d;
  logic [AW-1:0]       s1_addr_q, s1_addr_d;
  logic [PIX_BITS-1:0] s1_pix_q, s1_pix_d;
  logic [CW-1:0]       rd_col_q, rd_col_d;

  logic                s2_vld_q, s2_vld_d;
  logic                s2_last_q, s2_last_d;
  logic [AW-1:0]       s2_addr_q, s2_addr_d;
  logic [PIX_BITS-1:0] s2_pix_q, s2_pix_d;

  logic                wr_en_q, wr_en_d;
  logic [AW-1:0]       wr_addr_q, wr_addr_d;
  logic [WORD-1:0]     wr_data_q, wr_data_d;
  logic                frame_done_q, frame_done_d;
  logic                busy_q, busy_d;

  logic [ACC_W-1:0]    acc_mem [WIDTH];
  logic [ACC_W-1:0]    acc_rd_q;

  logic                start_c, accept_c, last_px_c;
  logic                acc_we_c;
  logic [CW-1:0]       acc_wcol_c;
  logic [LW-1:0]       acc_wlane_c;
  logic [CW-1:0]       cur_col_c;
  logic [LW-1:0]       cur_lane_c;
  logic [BW-1:0]       cur_br_c;
  logic [AW-1:0]       cur_base_c;

  // Counters, accumulator control and the two-stage write pipeline.
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    lane_d       = lane_q;
    br_d         = br_q;
    base_d       = base_q;
    s1_vld_d     = 1'b0;
    s1_last_d    = 1'b0;
    s1_addr_d    = s1_addr_q;
    s1_pix_d     = s1_pix_q;
    rd_col_d     = rd_col_q;
    acc_we_c     = 1'b0;
    acc_wcol_c   = col_q;
    acc_wlane_c  = lane_q;

    start_c    = pixel_valid & frame_start;
    accept_c   = pixel_valid & (frame_start | (state_q == FILL));
    cur_col_c  = start_c ? '0 : col_q;
    cur_lane_c = start_c ? '0 : lane_q;
    cur_br_c   = start_c ? '0 : br_q;
    cur_base_c = start_c ? '0 : base_q;
    last_px_c  = (cur_col_c == CW'(WIDTH - 1)) && (cur_lane_c == LW'(BLOCK - 1)) &&
                 (cur_br_c == BW'(ROWS_B - 1));

    if (accept_c) begin
      state_d  = FILL;
      rd_col_d = cur_col_c;
      s1_pix_d = pixel_data;
      if (cur_lane_c != LW'(BLOCK - 1)) begin
        acc_we_c    = 1'b1;
        acc_wcol_c  = cur_col_c;
        acc_wlane_c = cur_lane_c;
      end else begin
        s1_vld_d  = 1'b1;
        s1_addr_d = cur_base_c + AW'(cur_br_c);
        s1_last_d = last_px_c;
      end
      if (cur_col_c == CW'(WIDTH - 1)) begin
        col_d  = '0;
        base_d = '0;
        if (cur_lane_c == LW'(BLOCK - 1)) begin
          lane_d = '0;
          if (last_px_c) begin
            br_d    = '0;
            state_d = IDLE;
          end else begin
            br_d = cur_br_c + BW'(1);
          end
        end else begin
          lane_d = cur_lane_c + LW'(1);
          br_d   = cur_br_c;
        end
      end else begin
        col_d  = cur_col_c + CW'(1);
        base_d = cur_base_c + AW'(ROWS_B);
        lane_d = cur_lane_c;
        br_d   = cur_br_c;
      end
    end

    s2_vld_d  = s1_vld_q;
    s2_last_d = s1_last_q;
    s2_addr_d = s1_addr_q;
    s2_pix_d  = s1_pix_q;

    wr_en_d      = s2_vld_q;
    wr_addr_d    = s2_vld_q ? s2_addr_q : wr_addr_q;
    wr_data_d    = s2_vld_q ? {s2_pix_q, acc_rd_q} : wr_data_q;
    frame_done_d = s2_vld_q & s2_last_q;

    // A frame_start arriving while the final write drains keeps busy asserted.
    busy_d = busy_q;
    if (s2_vld_q && s2_last_q && (state_q == IDLE)) busy_d = 1'b0;
    if (start_c) busy_d = 1'b1;
  end

  always_ff @(posedge clk_100mhz) begin
    if (sys_rst) begin
      state_q      <= IDLE;
      col_q        <= '0;
      lane_q       <= '0;
      br_q         <= '0;
      base_q       <= '0;
      s1_vld_q     <= 1'b0;
      s1_last_q    <= 1'b0;
      s1_addr_q    <= '0;
      s1_pix_q     <= '0;
      rd_col_q     <= '0;
      s2_vld_q     <= 1'b0;
      s2_last_q    <= 1'b0;
      s2_addr_q    <= '0;
      s2_pix_q     <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      lane_q       <= lane_d;
      br_q         <= br_d;
      base_q       <= base_d;
      s1_vld_q     <= s1_vld_d;
      s1_last_q    <= s1_last_d;
      s1_addr_q    <= s1_addr_d;
      s1_pix_q     <= s1_pix_d;
      rd_col_q     <= rd_col_d;
      s2_vld_q     <= s2_vld_d;
      s2_last_q    <= s2_last_d;
      s2_addr_q    <= s2_addr_d;
      s2_pix_q     <= s2_pix_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

  // Column accumulator: no reset, contents are rewritten before each use.
  always_ff @(posedge clk_100mhz) begin
    if (acc_we_c) acc_mem[acc_wcol_c][acc_wlane_c * PIX_BITS +: PIX_BITS] <= pixel_data;
    acc_rd_q <= acc_mem[rd_col_q];
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_frame_block_writer.sv
// Randomized/directed bench for frame_block_writer against a raster-image reference model.
module tb_frame_block_writer;

  localparam int W   = 32;
  localparam int H   = 24;
  localparam int B   = 6;
  localparam int P   = 8;
  localparam int RB  = H / B;
  localparam int WD  = B * P;
  localparam int AW  = $clog2(W * RB);

  typedef struct {
    int            addr;
    logic [WD-1:0] data;
    int            cyc;
    bit            last;
  } wr_t;

  logic          clk = 1'b0;
  logic          sys_rst;
  logic          pixel_valid;
  logic [P-1:0]  pixel_data;
  logic          frame_start;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [WD-1:0] wr_data;
  logic          frame_done;
  logic          busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int nwr = 0;
  bit mon_on = 1'b0;

  logic [P-1:0]  img [H][W];
  bit            m_active = 1'b0;
  int            m_row = 0;
  int            m_col = 0;
  int            m_pushed = 0;
  wr_t           exp_q[$];
  wr_t           mon_e;
  int            wlog_addr[$];
  logic [WD-1:0] wlog_data[$];
  int            ref_addr[$];
  logic [WD-1:0] ref_data[$];

  frame_block_writer #(.WIDTH(W), .HEIGHT(H), .BLOCK(B), .PIX_BITS(P)) dut (
    .clk_100mhz (clk),
    .sys_rst    (sys_rst),
    .pixel_valid(pixel_valid),
    .pixel_data (pixel_data),
    .frame_start(frame_start),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .frame_done (frame_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
    end
  endtask

  // Reference: store each accepted pixel into the frame image; every BLOCK-th row
  // completes one column word per pixel, written 2 edges after that pixel is sampled.
  task automatic send(input logic [P-1:0] pix, input bit fs);
    wr_t e;
    @(negedge clk);
    pixel_valid = 1'b1;
    pixel_data  = pix;
    frame_start = fs;
    if (fs) begin
      m_active = 1'b1;
      m_row = 0;
      m_col = 0;
    end
    if (m_active) begin
      img[m_row][m_col] = pix;
      if (m_row % B == B - 1) begin
        e.addr = RB * m_col + m_row / B;
        for (int r = 0; r < B; r++) e.data[r*P +: P] = img[m_row - (B - 1) + r][m_col];
        e.cyc  = cyc + 3;
        e.last = (m_row == H - 1) && (m_col == W - 1);
        exp_q.push_back(e);
        m_pushed++;
      end
      if (m_col == W - 1) begin
        m_col = 0;
        m_row++;
        if (m_row == H) begin
          m_row = 0;
          m_active = 1'b0;
        end
      end else begin
        m_col++;
      end
    end
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(negedge clk);
      pixel_valid = 1'b0;
      frame_start = 1'b0;
      pixel_data  = P'($urandom);
    end
  endtask

  function automatic logic [P-1:0] pv(input int mode, input int r, input int c);
    if (mode == 0) return P'(r * 16 + c);
    if (mode == 1) return P'(r * 7 + c);
    return P'($urandom);
  endfunction

  // npx pixels in raster order starting at (r0, 0); optional random valid gaps.
  task automatic run(input int mode, input int r0, input int npx, input bit fs, input bit gapped);
    for (int k = 0; k < npx; k++) begin
      if (gapped) while ($urandom_range(1) == 1) gap(1);
      send(pv(mode, r0 + k / W, k % W), fs && (k == 0));
    end
  endtask

  task automatic drain();
    @(negedge clk);
    pixel_valid = 1'b0;
    frame_start = 1'b0;
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  always @(posedge clk) begin
    #1;
    if (mon_on) begin
      if (wr_en === 1'b1) begin
        nwr++;
        wlog_addr.push_back(int'(wr_addr));
        wlog_data.push_back(wr_data);
        checks++;
        assert (exp_q.size() > 0) else begin
          failures++;
          $error("FAIL unexpected_write observed=addr %0d data %h required=no write", wr_addr, wr_data);
        end
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          chk("wr_addr", 64'(wr_addr), 64'(mon_e.addr));
          chk("wr_data", 64'(wr_data), 64'(mon_e.data));
          chk("wr_cycle", 64'(cyc), 64'(mon_e.cyc));
          chk("frame_done_on_write", 64'(frame_done), 64'(mon_e.last));
          chk("busy_on_write", 64'(busy), 64'(!mon_e.last));
        end
      end else begin
        chk("frame_done_idle", 64'(frame_done), 64'd0);
      end
    end
  end

  initial begin
    int n0, mism, oldcnt, p0;
    sys_rst = 1'b1;
    pixel_valid = 1'b0;
    frame_start = 1'b0;
    pixel_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_wr_addr", 64'(wr_addr), 64'd0);
    chk("rst_wr_data", 64'(wr_data), 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    sys_rst = 1'b0;
    mon_on = 1'b1;

    // Single-word pack over six rows.
    run(0, 0, 5 * W, 1'b1, 1'b0);
    gap(3);
    chk("rows0_4_no_writes", 64'(nwr), 64'd0);
    run(0, 5, W, 1'b0, 1'b0);
    drain();
    chk("single_count", 64'(nwr), 64'(W));
    chk("single_first_addr", 64'(wlog_addr[0]), 64'd0);
    chk("single_first_data", 64'(wlog_data[0]), 64'h5040_3020_1000);
    mism = 0;
    for (int i = 0; i < wlog_addr.size(); i++) if (wlog_addr[i] != i * RB) mism++;
    chk("single_addr_seq", 64'(mism), 64'd0);
    chk("single_busy", 64'(busy), 64'd1);

    // Full ramp frame (restarts the partial frame above).
    wlog_addr.delete();
    wlog_data.delete();
    n0 = nwr;
    run(1, 0, H * W, 1'b1, 1'b0);
    drain();
    chk("ramp_count", 64'(nwr - n0), 64'(W * RB));
    chk("ramp_last_addr", 64'(wlog_addr[wlog_addr.size() - 1]), 64'(W * RB - 1));
    chk("ramp_busy_after", 64'(busy), 64'd0);
    ref_addr = wlog_addr;
    ref_data = wlog_data;

    // Post-frame pixels without frame_start are ignored.
    n0 = nwr;
    run(2, 0, 500, 1'b0, 1'b0);
    drain();
    chk("ignore_writes", 64'(nwr - n0), 64'd0);
    chk("ignore_busy", 64'(busy), 64'd0);

    // Same ramp with random pixel_valid gaps.
    wlog_addr.delete();
    wlog_data.delete();
    run(1, 0, H * W, 1'b1, 1'b1);
    drain();
    chk("gapped_count", 64'(wlog_addr.size()), 64'(ref_addr.size()));
    mism = 0;
    for (int i = 0; i < wlog_addr.size() && i < ref_addr.size(); i++)
      if (wlog_addr[i] != ref_addr[i] || wlog_data[i] !== ref_data[i]) mism++;
    chk("gapped_vs_gapfree", 64'(mism), 64'd0);
    chk("gapped_busy_after", 64'(busy), 64'd0);

    // Mid-frame restart with writes still in the pipeline.
    wlog_addr.delete();
    wlog_data.delete();
    p0 = m_pushed;
    run(2, 0, 11 * W + 10, 1'b1, 1'b0);
    oldcnt = m_pushed - p0;
    run(1, 0, 5 * W + 1, 1'b1, 1'b0);
    drain();
    chk("restart_total", 64'(wlog_addr.size()), 64'(oldcnt + 1));
    chk("restart_first_addr", 64'(wlog_addr[oldcnt]), 64'd0);
    chk("restart_first_data", 64'(wlog_data[oldcnt]), 64'h231C_150E_0700);
    chk("restart_busy", 64'(busy), 64'd1);

    // Reset while a write is in flight.
    run(2, 0, 5 * W + 1, 1'b1, 1'b0);
    @(negedge clk);
    mon_on = 1'b0;
    sys_rst = 1'b1;
    pixel_valid = 1'b0;
    frame_start = 1'b0;
    exp_q.delete();
    m_active = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_wr_en", 64'(wr_en), 64'd0);
    chk("midrst_wr_addr", 64'(wr_addr), 64'd0);
    chk("midrst_wr_data", 64'(wr_data), 64'd0);
    chk("midrst_frame_done", 64'(frame_done), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    sys_rst = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_squash", 64'(wr_en), 64'd0);
    mon_on = 1'b1;
    n0 = nwr;
    run(2, 0, 40, 1'b0, 1'b0);
    drain();
    chk("postrst_no_writes", 64'(nwr - n0), 64'd0);
    chk("postrst_busy", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/frame_block_writer.md
# frame_block_writer

Write-side packer for the stereo left/right frame buffers. Accepts a raster-order stream of 8-bit grayscale pixels from the camera path. Packs each group of 6 vertically adjacent pixels in one column into a 48-bit word and writes that word into the single-port frame-buffer BRAM. Word address is 40*column + block_row, the same layout the stereo matcher reads. One instance drives each of the left and right buffers.

## Interface
Parameters:
- WIDTH, 320: pixels per row (columns).
- HEIGHT, 240: rows per frame; must be a multiple of BLOCK.
- BLOCK, 6: vertically adjacent pixels packed per word.
- PIX_BITS, 8: bits per pixel.
- Derived: ROWS_B = HEIGHT/BLOCK (40); WORD = BLOCK*PIX_BITS (48); AW = $clog2(WIDTH*ROWS_B) (14).

Ports (one clock; reset is synchronous and active-high):
- clk_100mhz  in  1  system clock; all logic on its rising edge.
- sys_rst  in  1  synchronous, active-high reset.
- pixel_valid  in  1  pixel_data is valid this cycle; sampled every edge (no backpressure).
- pixel_data  in  PIX_BITS  grayscale pixel.
- frame_start  in  1  qualified by pixel_valid; marks the pixel as row 0, column 0.
- wr_en  out  1  BRAM write enable (to wea).
- wr_addr  out  AW  BRAM address = ROWS_B*col + block_row.
- wr_data  out  WORD  packed word; lane r = bits [PIX_BITS*r +: PIX_BITS] holds row (block_row*BLOCK + r).
- frame_done  out  1  one-cycle pulse, coincident with the last write of a frame.
- busy  out  1  high from an accepted frame_start until the frame's last write.

## Operation
- State machine:
  - IDLE: pixels without frame_start are ignored.
  - FILL: accepting pixels.
  - Transitions:
    - Accepted frame_start in any state → FILL, with col=0, row=0.
    - Final pixel accepted (col=WIDTH-1, row=HEIGHT-1) → IDLE.
- Counters in FILL, per accepted pixel:
  - col increments; at WIDTH-1 it wraps to 0 and row increments.
  - lane = row mod BLOCK, tracked as a separate wrapping counter (no divider).
  - block_row increments when lane wraps from BLOCK-1 to 0.
- Accumulator: WIDTH entries of (BLOCK-1)*PIX_BITS bits (320 x 40 b), indexed by col.
  - lane < BLOCK-1: pixel is written into accumulator[col] at lane bits; no BRAM write.
  - lane = BLOCK-1: the stored BLOCK-1 lanes of accumulator[col] are concatenated with the new pixel in the top lane. The result is issued as one BRAM write at wr_addr = ROWS_B*col + block_row.
- Address arithmetic: ROWS_B*col uses constant multiply, or an incrementing base that adds ROWS_B per column and resets at row wrap. Max address = WIDTH*ROWS_B-1 = 12799; never exceeds it.
- Exactly WIDTH*ROWS_B (12800) writes per complete frame, in order: block_row ascending, col ascending within each block_row.
- frame_start mid-frame: counters restart at (0,0) with this pixel. Stale accumulator lanes are overwritten before any write uses them. Writes already in the pipeline still complete.
- Pixels after frame completion without a new frame_start: ignored (no writes, busy low).
- Reset: all counters 0, state IDLE. Outputs: wr_en=0, wr_addr=0, wr_data=0, frame_done=0, busy=0. Accumulator contents are don't-care. In-flight writes are squashed, so wr_en is 0 on the cycle after reset is sampled.

## Timing
- Pixel sampled at edge k; accumulator read issued at edge k.
- Combine and output registers are loaded at edge k+2. wr_en/wr_addr/wr_data are valid from edge k+2 for exactly one cycle, giving a fixed latency of 2 cycles.
- Throughput: one pixel per cycle sustained. Gaps in pixel_valid insert gaps in writes, with no state change.
- No accumulator read-after-write hazard: the same col is revisited at least WIDTH cycles later.
- frame_done and the busy fall both occur at edge k+2 of the final pixel, together with the final wr_en.
- wr_en is never high for two writes to the same address within a frame.

## Test plan
- Single-word pack: frame_start, then 6 rows of WIDTH pixels with value = (row*16 + col) mod 256. Required response:
  - First write: addr 0, data 0x504030201000.
  - 320 writes total, at addresses 0, 40, …, 12760.
  - No writes during rows 0–4.
- Full frame with a ramp (value = (row*7 + col) mod 256):
  - Scoreboard all 12800 writes against the lane formula.
  - Last write at addr 12799, with frame_done high on that same cycle.
  - busy low afterwards.
- Gapped input: pixel_valid toggled randomly (about 50%) over a full frame. Required: identical write contents and order to the gap-free run; each write 2 cycles after its sixth-row pixel.
- Mid-frame restart: frame_start asserted at row 8, col 100. Required:
  - Previous pipeline writes still complete.
  - New frame's first write at addr 0 after 5 more full rows and 1 pixel.
  - New frame's write data has no lanes from the old frame.
- Reset mid-frame: sys_rst for 1 cycle while a write is in flight. Required: wr_en=0 on the next cycle, all outputs 0. Then pixels without frame_start produce no writes.
- Post-frame ignore: after frame_done, 500 valid pixels without frame_start. Required: zero writes, busy=0.
